// File: rtl/frame_swapchain.sv
// frame_swapchain: multi-buffer framebuffer with a read-only scan-out port (A)
// on the front buffer and a read/write render port (B) on the back buffer.
// Swaps wait for vertical blanking; an optional clear engine then fills the new
// back buffer with CLEAR_VALUE, one word per cycle.
// Latency: a_data/b_data are registered, valid 1 cycle after the address.
// Backpressure: b_ready drops while the clear engine owns the write port, and
// b_we is ignored while it is low. Port A is never stalled.
//
// Ports:
//   clock, reset            clock, async active-high reset
//   a_x, a_y -> a_data      scan-out read of the front buffer
//   b_x, b_y, b_we, b_wdata render access to the back buffer, b_data read data
//   b_ready                 render port accepts access (low while clearing)
//   vblank, swap_req        blanking level, one-cycle swap request
//   clear_on_swap           request a clear of the new back buffer after swap
//   swap_pending, swap_done swap status / one-cycle pulse when it executes
//   clearing, front_idx     clear engine busy, current front buffer index
module frame_swapchain #(
  parameter int                 PIXEL_W     = 24,
  parameter int                 X_W         = 10,
  parameter int                 Y_W         = 9,
  parameter int                 NUM_BUF     = 2,
  parameter logic [PIXEL_W-1:0] CLEAR_VALUE = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [X_W-1:0]     a_x,
  input  logic [Y_W-1:0]     a_y,
  output logic [PIXEL_W-1:0] a_data,
  input  logic [X_W-1:0]     b_x,
  input  logic [Y_W-1:0]     b_y,
  input  logic               b_we,
  input  logic [PIXEL_W-1:0] b_wdata,
  output logic [PIXEL_W-1:0] b_data,
  output logic               b_ready,
  input  logic               vblank,
  input  logic               swap_req,
  input  logic               clear_on_swap,
  output logic               swap_pending,
  output logic               swap_done,
  output logic               clearing,
  output logic [1:0]         front_idx
);

  localparam int AW    = X_W + Y_W;
  localparam int DEPTH = 1 << AW;
  // Buffers are stacked in one array; since DEPTH is a power of two the
  // flat index of (buffer, pixel) is simply {buffer, pixel}.
  localparam int IW    = $clog2(NUM_BUF * DEPTH);
  localparam logic [1:0] LAST_IDX = 2'(NUM_BUF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PENDING,
    S_CLEAR
  } state_t;

  state_t            state;
  logic              clr_flag;
  logic [AW-1:0]     clr_addr;
  logic [1:0]        back_idx;

  logic              wr_en;
  logic [AW-1:0]     wr_lin;
  logic [PIXEL_W-1:0] wr_dat;
  logic [IW-1:0]     wr_idx;
  logic [IW-1:0]     a_idx;
  logic [IW-1:0]     b_idx;

  logic [PIXEL_W-1:0] mem [NUM_BUF*DEPTH];

  // The back buffer is always the one after the front; a swap promotes it.
  assign back_idx = (front_idx == LAST_IDX) ? 2'd0 : front_idx + 2'd1;

  assign b_ready  = ~clearing;

  // Single write port shared between the clear engine and the render port;
  // the clear engine wins, which is exactly when b_ready is low.
  assign wr_en  = clearing | b_we;
  assign wr_lin = clearing ? clr_addr : {b_y, b_x};
  assign wr_dat = clearing ? CLEAR_VALUE : b_wdata;
  assign wr_idx = IW'({back_idx, wr_lin});
  assign a_idx  = IW'({front_idx, a_y, a_x});
  assign b_idx  = IW'({back_idx, b_y, b_x});

  // Storage is deliberately not reset; an aborted clear leaves what it wrote.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_dat;
    end
  end

  // Reads sample the array before this edge's write lands (read-before-write).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_data <= '0;
      b_data <= '0;
    end else begin
      a_data <= mem[a_idx];
      b_data <= mem[b_idx];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      front_idx    <= 2'd0;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
      clearing     <= 1'b0;
      clr_flag     <= 1'b0;
      clr_addr     <= '0;
    end else begin
      swap_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (swap_req) begin
            clr_flag     <= clear_on_swap;
            swap_pending <= 1'b1;
            state        <= S_PENDING;
          end
        end

        S_PENDING: begin
          if (vblank) begin
            front_idx    <= back_idx;
            swap_done    <= 1'b1;
            swap_pending <= 1'b0;
            clr_flag     <= 1'b0;
            // A repeat request arriving on the swap cycle still contributes
            // its clear request; the swap itself is not repeated.
            if (clr_flag | (swap_req & clear_on_swap)) begin
              clearing <= 1'b1;
              clr_addr <= '0;
              state    <= S_CLEAR;
            end else begin
              state <= S_IDLE;
            end
          end else if (swap_req) begin
            clr_flag <= clr_flag | clear_on_swap;
          end
        end

        S_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          // Requests during a clear are queued; clr_flag was consumed at the
          // swap that started this clear, so it now holds only new requests.
          if (swap_req) begin
            swap_pending <= 1'b1;
            clr_flag     <= clr_flag | clear_on_swap;
          end
          if (clr_addr == {AW{1'b1}}) begin
            clearing <= 1'b0;
            state    <= (swap_pending | swap_req) ? S_PENDING : S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
